// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug loader) arbiter onto a single synchronous data memory.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed CPU priority.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ack,
  output logic              c_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  state_t              state_q, state_d;
  logic                lat_id_q, lat_id_d;
  logic                lat_we_q, lat_we_d;
  logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;

  logic                m_en_d, m_we_d;
  logic [ADDR_W-1:0]   m_addr_d;
  logic [DATA_W-1:0]   m_wdata_d;
  logic                c_ack_d, d_ack_d, busy_d;

  logic                any_req;
  logic                grant_dbg;

  assign any_req = c_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer names the preferred port on a tie; it flips to the other port on every grant.
  logic prio_dbg_q;

  assign grant_dbg = d_req & (~c_req | prio_dbg_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_dbg_q <= 1'b0;
    end else if ((state_q == IDLE) && any_req) begin
      prio_dbg_q <= ~grant_dbg;
    end
  end
`else
  assign grant_dbg = d_req & ~c_req;
`endif

  // Next-state, latch and registered-output decode.
  always_comb begin
    state_d     = state_q;
    lat_id_d    = lat_id_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    m_en_d      = 1'b0;
    m_we_d      = 1'b0;
    m_addr_d    = '0;
    m_wdata_d   = '0;
    c_ack_d     = 1'b0;
    d_ack_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = ACCESS;
          lat_id_d    = grant_dbg ? PORT_DBG : PORT_CPU;
          lat_we_d    = grant_dbg ? d_we : c_we;
          lat_addr_d  = grant_dbg ? d_addr : c_addr;
          lat_wdata_d = grant_dbg ? d_wdata : c_wdata;
          m_en_d      = 1'b1;
          m_we_d      = lat_we_d;
          m_addr_d    = lat_addr_d;
          m_wdata_d   = lat_wdata_d;
        end
      end
      ACCESS: begin
        state_d = RESP;
        c_ack_d = (lat_id_q == PORT_CPU);
        d_ack_d = (lat_id_q == PORT_DBG);
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lat_id_q    <= PORT_CPU;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      m_en        <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      c_ack       <= 1'b0;
      d_ack       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_id_q    <= lat_id_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      m_en        <= m_en_d;
      m_we        <= m_we_d;
      m_addr      <= m_addr_d;
      m_wdata     <= m_wdata_d;
      c_ack       <= c_ack_d;
      d_ack       <= d_ack_d;
      busy        <= busy_d;
    end
  end

  // Memory read data only arrives in the ack cycle, so load data is steered straight through.
  assign c_rdata = (c_ack && !lat_we_q) ? m_rdata : '0;
  assign d_rdata = (d_ack && !lat_we_q) ? m_rdata : '0;

  assign c_stall = c_req & ~c_ack;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address buses.
REQ-002 Parameter DATA_W, default 32, width of all data buses.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 c_req  input  1  CPU data-port request, held high until c_ack.
REQ-006 c_we  input  1  CPU request is a store (1) or load (0).
REQ-007 c_addr  input  ADDR_W  CPU byte address.
REQ-008 c_wdata  input  DATA_W  CPU store data.
REQ-009 c_rdata  output  DATA_W  CPU load data, valid only in the c_ack cycle.
REQ-010 c_ack  output  1  one-cycle pulse: CPU transaction complete.
REQ-011 c_stall  output  1  c_req high and c_ack low; freezes CPU PC and register writeback.
REQ-012 d_req / d_we / d_addr / d_wdata / d_rdata / d_ack  same directions, widths and meanings as the c_* ports, for the debug/loader port.
REQ-013 m_en  output  1  memory access strobe.
REQ-014 m_we  output  1  memory write enable, qualified by m_en.
REQ-015 m_addr  output  ADDR_W  memory address.
REQ-016 m_wdata  output  DATA_W  memory write data.
REQ-017 m_rdata  input  DATA_W  memory read data, valid one cycle after the m_en cycle.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-020 IDLE: when any request is high at a clock edge, the FSM SHALL latch the winner's id, we, addr and wdata, then move to ACCESS.
REQ-021 ACCESS: the block SHALL drive m_en=1 and m_we/m_addr/m_wdata from the latched copy for exactly one cycle, then move to RESP.
REQ-022 RESP: the block SHALL pulse the winner's ack for one cycle, drive its rdata from m_rdata (0 for stores), then return to IDLE.
REQ-023 The loser's ack SHALL stay 0, and its rdata SHALL stay 0 throughout.
REQ-024 Latency from request seen in IDLE to ack SHALL be exactly 2 cycles, so one transaction completes every 3 cycles.
REQ-025 The block SHALL sample requests only in IDLE; input changes in ACCESS or RESP SHALL not affect the transaction in flight.
REQ-026 A request still high in the cycle after its ack SHALL be treated as a new transaction.
REQ-027 With no request in IDLE, m_en SHALL be 0 and the state SHALL remain IDLE.
REQ-028 Simultaneous c_req and d_req SHALL be resolved per REQ-034/REQ-035; exactly one port is granted per transaction.
REQ-029 c_stall SHALL be combinational and SHALL be 0 whenever c_req is 0.
REQ-030 Address and data SHALL pass unmodified at full width, with no alignment checking.

Reset
REQ-031 Reset SHALL force IDLE and clear the latched request registers and the round-robin pointer (pointer = CPU preferred).
REQ-032 Reset SHALL force m_en, m_we, m_addr, m_wdata, c_ack, d_ack, c_rdata, d_rdata and busy to 0; c_stall follows REQ-029.
REQ-033 Reset during ACCESS: the memory write presented in that cycle SHALL still commit at that edge. The block SHALL abandon the transaction and issue no ack.

Configuration
REQ-034 With ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the port not granted most recently SHALL win. The pointer SHALL update on each grant.
REQ-035 Without ARB_ROUND_ROBIN_EN: fixed priority SHALL apply, with the CPU always winning simultaneous requests and no pointer register.

Verification
REQ-036 c_req=1, c_we=1, addr=0x10, wdata=0xDEADBEEF -> m_en=1, m_we=1 in cycle 1; c_ack in cycle 2; memory[0x10]=0xDEADBEEF.
REQ-037 Load from 0x10 after REQ-036 -> c_ack in cycle 2 with c_rdata=0xDEADBEEF; c_stall high in cycles 0-1 and low in cycle 2.
REQ-038 c_req and d_req both held high for 6 cycles -> without the macro: two CPU grants. With ARB_ROUND_ROBIN_EN: CPU then debug.
REQ-039 d_req store to 0x20 while CPU is idle -> d_ack in cycle 2; c_ack stays 0 and c_stall stays 0.
REQ-040 Reset asserted in ACCESS of a store to 0x30 = 0x55 -> memory[0x30]=0x55, no ack, IDLE and all outputs 0 after the edge.
REQ-041 d_req arrives during CPU ACCESS -> debug granted on the IDLE cycle after c_ack; CPU data unaffected.
